// File: rtl/fpu_div_sched_if.sv
// Request, response and shared-divider signals for fpu_div_sched.
// slave is the scheduler's view; master is the issue logic / consumer / divider side.
interface fpu_div_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = 16,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;

  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_q;
  logic [5:0]        resp_flags;
  logic [4:0]        resp_exc;

  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic [W-1:0]      div_q;
  logic [5:0]        div_flags;
  logic [4:0]        div_exc;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, div_q, div_flags, div_exc,
    output req_ready, resp_valid, resp_id, resp_q, resp_flags, resp_exc, div_a, div_b
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, div_q, div_flags, div_exc,
    input  req_ready, resp_valid, resp_id, resp_q, resp_flags, resp_exc, div_a, div_b
  );
endinterface

// File: rtl/fpu_div_sched.sv
// Round-robin sequencer sharing one external bf16 divider between NREQ requesters:
// accept one op, hold operands for LAT cycles, capture the divider outputs, return them.
module fpu_div_sched #(
  parameter int NEXP = 8,
  parameter int NSIG = 7,
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fpu_div_sched_if.slave bus,
  output logic           busy
);

  localparam int W   = NEXP + NSIG + 1;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   q_q, q_d;
  logic [5:0]     flg_q, flg_d;
  logic [4:0]     exc_q, exc_d;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;

  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Scan from the highest offset down so the nearest valid index at or after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx(ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rot_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state_q == IDLE && gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    q_d     = q_q;
    flg_d   = flg_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          opa_d   = bus.req_a[gnt_idx*W +: W];
          opb_d   = bus.req_b[gnt_idx*W +: W];
          id_d    = gnt_idx;
          cnt_d   = CW'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          q_d     = bus.div_q;
          flg_d   = bus.div_flags;
          exc_d   = bus.div_exc;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          ptr_d   = wrap_inc(id_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      q_q     <= '0;
      flg_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      q_q     <= q_d;
      flg_q   <= flg_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.div_a      = opa_q;
  assign bus.div_b      = opb_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_q     = q_q;
  assign bus.resp_flags = flg_q;
  assign bus.resp_exc   = exc_q;
  assign busy           = (state_q != IDLE);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  a_no_grant_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (bus.req_ready == '0));

  a_operands_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE && $past(state_q) != IDLE) |-> $stable({opa_q, opb_q}));

  a_resp_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RESP && $past(state_q) == RESP) |-> $stable({id_q, q_q, flg_q, exc_q}));

  a_wait_count_live: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WAIT) |-> (cnt_q != '0));

endmodule

// File: tb/tb_fpu_div_sched.sv
// Self-checking bench for fpu_div_sched: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration, latency and capture timing.
module tb_fpu_div_sched;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int W    = 16;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  fpu_div_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  fpu_div_sched #(.NEXP(8), .NSIG(7), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external divider: correct-looking results for the known cases,
  // a deterministic mix otherwise; junk while operands are still settling.
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h40C0 && b == 16'h4000) return 16'h4040;
    if (b[14:0] == 15'd0 && a[14:0] != 15'd0 && a[14:7] != 8'hFF) return {a[15] ^ b[15], 8'hFF, 7'h00};
    return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]};
  endfunction

  function automatic logic [5:0] flags_at(input int c);
    return 6'(c * 37 + 11);
  endfunction

  function automatic logic [4:0] exc_at(input int c);
    return 5'(c * 13 + 5);
  endfunction

  logic [15:0] pa = '0, pb = '0;
  int chg = 0;
  always @(negedge clk) begin
    if (bus.div_a !== pa || bus.div_b !== pb) chg <= cyc;
    pa <= bus.div_a;
    pb <= bus.div_b;
  end

  assign bus.div_q = (bus.div_a === pa && bus.div_b === pb && cyc > chg)
                     ? ref_div(bus.div_a, bus.div_b) : (16'hDEAD ^ 16'(cyc));
  assign bus.div_flags = flags_at(cyc);
  assign bus.div_exc   = exc_at(cyc);

  // Requester intentions and model state
  int          ops [NREQ];
  bit          rv  [NREQ];
  logic [15:0] ra  [NREQ];
  logic [15:0] rb  [NREQ];
  bit          rnd = 0;

  bit          out_m = 0;
  int          ptr_m = 0;
  int          id_m = 0;
  int          acc_cyc_m = 0;
  int          last_acc = -1;
  logic [15:0] a_m = '0, b_m = '0;
  logic [15:0] lasta_m = '0, lastb_m = '0;
  int          served[$];
  int          acc_cycles[$];
  logic [15:0] last_q = '0;
  int          last_id = 0;
  int          first_rv_cyc = 0;
  bit          seen_rv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]         = rv[i];
      bus.req_a[i*W +: W]      = ra[i];
      bus.req_b[i*W +: W]      = rb[i];
    end
  endtask

  task automatic model_reset();
    out_m = 0; ptr_m = 0; lasta_m = '0; lastb_m = '0; last_acc = -1; seen_rv = 0;
  endtask

  task automatic tick();
    int g;
    bit exp_rv;
    @(negedge clk);
    exp_rv = out_m && (cyc >= acc_cyc_m + LAT + 1);
    chk("busy", 32'(busy), 32'(out_m));
    chk("div_a", 32'(bus.div_a), 32'(lasta_m));
    chk("div_b", 32'(bus.div_b), 32'(lastb_m));
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("resp_id", 32'(bus.resp_id), 32'(id_m));
      chk("resp_q", 32'(bus.resp_q), 32'(ref_div(a_m, b_m)));
      chk("resp_flags", 32'(bus.resp_flags), 32'(flags_at(acc_cyc_m + LAT)));
      chk("resp_exc", 32'(bus.resp_exc), 32'(exc_at(acc_cyc_m + LAT)));
    end
    if (bus.resp_valid && !seen_rv) begin
      seen_rv = 1;
      first_rv_cyc = cyc;
    end
    g = -1;
    if (!out_m)
      for (int k = NREQ - 1; k >= 0; k--)
        if (rv[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (exp_rv && bus.resp_ready) begin
      last_q  = bus.resp_q;
      last_id = int'(bus.resp_id);
      out_m   = 0;
      ptr_m   = (id_m + 1) % NREQ;
    end
    if (g >= 0) begin
      if (last_acc >= 0) chk("grant_spacing", 32'(cyc - last_acc >= LAT + 2), 32'd1);
      out_m = 1; id_m = g; acc_cyc_m = cyc; a_m = ra[g]; b_m = rb[g];
      lasta_m = ra[g]; lastb_m = rb[g]; last_acc = cyc; seen_rv = 0;
      served.push_back(g);
      acc_cycles.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      ops[g]--;
      if (ops[g] > 0) begin
        ra[g] = 16'($urandom); rb[g] = 16'($urandom);
      end else rv[g] = 0;
    end
    for (int i = 0; i < NREQ; i++)
      if (!rv[i] && ops[i] > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        rv[i] = 1; ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      end
    if (rnd) bus.resp_ready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((ops[0] > 0 || ops[1] > 0 || out_m) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = 0; rv[i] = 0; ra[i] = '0; rb[i] = '0;
    end
    bus.resp_ready = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_div_a", 32'(bus.div_a), 32'd0);
    chk("rst_resp_q", 32'(bus.resp_q), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    rst_n = 1'b1;

    // Single op 6.0 / 2.0 from requester 0
    bus.resp_ready = 1'b1;
    ops[0] = 1; rv[0] = 1; ra[0] = 16'h40C0; rb[0] = 16'h4000;
    drive();
    run_until_idle(50);
    chk("single_q", 32'(last_q), 32'h4040);
    chk("single_id", 32'(last_id), 32'd0);
    chk("single_latency", 32'(first_rv_cyc - acc_cycles[acc_cycles.size()-1]), 32'(LAT + 1));

    // Divide by zero from requester 1
    ops[1] = 1; rv[1] = 1; ra[1] = 16'h3F80; rb[1] = 16'h0000;
    drive();
    run_until_idle(50);
    chk("divzero_q", 32'(last_q), 32'h7F80);
    chk("divzero_id", 32'(last_id), 32'd1);

    // Contention after reset: strict alternation, fixed spacing
    apply_reset();
    served.delete(); acc_cycles.delete();
    ops[0] = 3; ops[1] = 3; rv[0] = 1; rv[1] = 1;
    ra[0] = 16'($urandom); rb[0] = 16'($urandom); ra[1] = 16'($urandom); rb[1] = 16'($urandom);
    drive();
    run_until_idle(200);
    chk("contend_count", 32'(served.size()), 32'd6);
    for (int k = 0; k < 6 && k < served.size(); k++) chk("contend_order", 32'(served[k]), 32'(k % 2));
    for (int k = 1; k < 6 && k < acc_cycles.size(); k++)
      chk("contend_period", 32'(acc_cycles[k] - acc_cycles[k-1]), 32'(LAT + 2));

    // Backpressure for 5 cycles in RESP with a competing request pending
    bus.resp_ready = 1'b0;
    ops[0] = 1; rv[0] = 1; ra[0] = 16'($urandom); rb[0] = 16'($urandom);
    drive();
    tick();
    repeat (LAT) tick();
    ops[1] = 1; rv[1] = 1; ra[1] = 16'($urandom); rb[1] = 16'($urandom);
    drive();
    repeat (5) tick();
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_idle_after_ready", 32'(busy), 32'd0);
    run_until_idle(50);

    // Reset mid-WAIT: pointer must return to requester 0
    ops[0] = 1; rv[0] = 1; ra[0] = 16'($urandom); rb[0] = 16'($urandom);
    drive();
    run_until_idle(50);
    ops[1] = 1; rv[1] = 1; ra[1] = 16'h1234; rb[1] = 16'h5678;
    drive();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_div_a", 32'(bus.div_a), 32'd0);
    chk("arst_div_b", 32'(bus.div_b), 32'd0);
    model_reset();
    served.delete(); acc_cycles.delete();
    ops[0] = 1; ops[1] = 1; rv[0] = 1; rv[1] = 1;
    ra[0] = 16'($urandom); rb[0] = 16'($urandom); ra[1] = 16'($urandom); rb[1] = 16'($urandom);
    drive();
    #1;
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_until_idle(50);
    chk("arst_first_grant", 32'(served.size() > 0 ? served[0] : -1), 32'd0);

    // Operand stability: requester changes its operand while the op is in flight
    ops[0] = 1; rv[0] = 1; ra[0] = 16'h4100; rb[0] = 16'h3F00;
    drive();
    tick();
    ra[0] = 16'hFFFF; rb[0] = 16'h0001;
    drive();
    run_until_idle(50);
    chk("stable_q", 32'(last_q), 32'(ref_div(16'h4100, 16'h3F00)));

    // Randomized traffic with random backpressure
    rnd = 1;
    for (int i = 0; i < NREQ; i++) ops[i] = $urandom_range(5, 15);
    run_until_idle(3000);
    rnd = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_div_sched.md
Name: fpu_div_sched

Overview:
Sequencer and round-robin arbiter that shares one bf16 divide datapath (reciprocal followed by multiply, instantiated outside this block) between NREQ requesters. It accepts one operation at a time over a valid/ready handshake and holds the operands stable on the divider inputs. It waits a programmed settle latency, then captures the quotient, status flags and exception bits. It returns the result with the requester's ID over a response handshake. It sits between the FPU issue logic and the divider.

Parameters:
NEXP, 8, exponent width
NSIG, 7, stored significand width; W = NEXP+NSIG+1
NREQ, 2, number of requesters (2..8)
LAT, 2, cycles the divider needs to settle after operands change (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*W  dividends, requester i at [i*W +: W]
req_b  in  NREQ*W  divisors, same packing
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  clog2(NREQ) (min 1)  originating requester index
resp_q  out  W  quotient
resp_flags  out  6  divider bfFlags, captured
resp_exc  out  5  divider exception bits, captured
div_a  out  W  dividend to shared divider
div_b  out  W  divisor to shared divider
div_q  in  W  divider quotient
div_flags  in  6  divider bfFlags
div_exc  in  5  divider exception
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state IDLE, rr pointer 0, wait counter 0.
  - Operand, ID and response registers all 0.
  - resp_valid 0, req_ready 0, busy 0.
- States:
  - IDLE. Grant goes to the first index with req_valid set, searching from ptr upward and wrapping modulo NREQ. req_ready[grant] = 1 combinationally, in IDLE only; all other bits are 0. On req_valid & req_ready: latch req_a/req_b slices into the operand regs, latch the grant index into the ID reg, load counter = LAT, go to WAIT. With no valid requests, stay in IDLE.
  - WAIT. The counter decrements each cycle. In the cycle where the counter == 1: capture div_q, div_flags and div_exc into the response regs, then go to RESP.
  - RESP. resp_valid = 1. On resp_ready: go to IDLE and set ptr = (resp_id+1) mod NREQ. Otherwise hold every response output stable.
- div_a/div_b are driven directly from the operand regs. They do not change from acceptance until the next acceptance.
- Timing: handshake in cycle 0; WAIT occupies cycles 1..LAT; resp_valid first high in cycle LAT+1. The earliest next accept is cycle LAT+2, so the back-to-back period is LAT+2 cycles.
- One operation outstanding; no request is accepted in WAIT or RESP.
- Requesters must hold valid and operands until ready. A valid dropped before grant is simply not served.
- Simultaneous requests: exactly one grant per IDLE cycle. Rotating priority guarantees each requester waits at most NREQ-1 operations.
- No arithmetic is done in this block. Special cases (zero divisor, inf, NaN, subnormal) pass through from the divider unmodified.
- Reset asserted mid-operation: the in-flight operation is dropped with no response. Outputs go to reset values immediately (asynchronously).

Test Plan:
- Single op, LAT=2: req0 a=0x40C0 (6.0), b=0x4000 (2.0), resp_ready=1 -> req_ready[0] high in cycle 0; resp_valid in cycle 3 with resp_q=0x4040, resp_id=0; busy high cycles 1-3.
- Divide by zero: req1 a=0x3F80, b=0x0000 -> resp_q=0x7F80 (+inf), resp_id=1. resp_flags and resp_exc must equal the divider's outputs sampled at end of the last WAIT cycle.
- Contention after reset: req0 and req1 both held valid, each for 3 ops -> service order 0,1,0,1,0,1. Grants are spaced exactly LAT+2 cycles apart; req_ready is never two-hot.
- Backpressure: resp_ready low for 5 cycles in RESP -> resp_valid, resp_q and resp_id stable; req_ready=0 throughout. One cycle after resp_ready rises, state is IDLE.
- Reset mid-WAIT: assert rst_n=0 one cycle after accept -> resp_valid, busy and div_a go 0 without a clock edge. After release, no response appears and the next grant goes to req0.
- Operand stability: change req_a[0] during WAIT -> div_a unchanged; the result reflects the originally accepted operands.
